// File: rtl/wb_arbiter_n_if.sv
// Bus bundle between N Wishbone masters, the arbiter and the single slave port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface wb_arbiter_n_if #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64
);
    localparam int unsigned SelW = DATA_W / 8;
    localparam int unsigned GntW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS*ADDR_W-1:0] i_m_wb_adr;
    logic [NUM_MASTERS*DATA_W-1:0] i_m_wb_dat;
    logic [DATA_W-1:0]             o_m_wb_dat;
    logic [NUM_MASTERS-1:0]        i_m_wb_we;
    logic [NUM_MASTERS*SelW-1:0]   i_m_wb_sel;
    logic [NUM_MASTERS-1:0]        i_m_wb_stb;
    logic [NUM_MASTERS-1:0]        i_m_wb_cyc;
    logic [NUM_MASTERS-1:0]        i_m_wb_lock;
    logic [NUM_MASTERS-1:0]        o_m_wb_ack;
    logic [NUM_MASTERS-1:0]        o_m_wb_stall;
    logic [NUM_MASTERS-1:0]        o_m_wb_rty;
    logic [ADDR_W-1:0]             o_wb_adr;
    logic [DATA_W-1:0]             o_wb_dat;
    logic                          o_wb_we;
    logic [SelW-1:0]               o_wb_sel;
    logic                          o_wb_stb;
    logic                          o_wb_cyc;
    logic [DATA_W-1:0]             i_wb_dat;
    logic                          i_wb_ack;
    logic                          i_wb_stall;
    logic [GntW-1:0]               o_grant_idx;
    logic                          o_busy;

    modport slave (
        input  i_m_wb_adr, i_m_wb_dat, i_m_wb_we, i_m_wb_sel, i_m_wb_stb, i_m_wb_cyc,
        input  i_m_wb_lock, i_wb_dat, i_wb_ack, i_wb_stall,
        output o_m_wb_dat, o_m_wb_ack, o_m_wb_stall, o_m_wb_rty,
        output o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
        output o_grant_idx, o_busy
    );

    modport master (
        output i_m_wb_adr, i_m_wb_dat, i_m_wb_we, i_m_wb_sel, i_m_wb_stb, i_m_wb_cyc,
        output i_m_wb_lock, i_wb_dat, i_wb_ack, i_wb_stall,
        input  o_m_wb_dat, o_m_wb_ack, o_m_wb_stall, o_m_wb_rty,
        input  o_wb_adr, o_wb_dat, o_wb_we, o_wb_sel, o_wb_stb, o_wb_cyc,
        input  o_grant_idx, o_busy
    );
endinterface

// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave pipelined Wishbone arbiter with fixed/round-robin arbitration,
// bus lock, outstanding-strobe limiting and a slave-timeout abort that answers RTY.
module wb_arbiter_n #(
    parameter int unsigned NUM_MASTERS     = 3,
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned ARB_MODE        = 0,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input logic           i_clk,
    input logic           i_reset,
    wb_arbiter_n_if.slave bus
);
    localparam int unsigned SelW = DATA_W / 8;
    localparam int unsigned GntW = $clog2(NUM_MASTERS);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TmrW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUTSTANDING);
    localparam logic [TmrW-1:0] TmrLast = TmrW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {StIdle, StBusy, StHold, StAbort} state_e;

    state_e          state_q, state_d;
    logic [GntW-1:0] grant_q, grant_d;
    logic [GntW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [TmrW-1:0] timer_q, timer_d;
    logic [GntW-1:0] winner, idx, ptr_nxt;
    logic            found, any_cyc, own_cyc, own_stb, own_lock, full, accept, ack_ok;

    assign any_cyc  = |bus.i_m_wb_cyc;
    assign own_cyc  = bus.i_m_wb_cyc[grant_q];
    assign own_stb  = bus.i_m_wb_stb[grant_q];
    assign own_lock = bus.i_m_wb_lock[grant_q];
    assign full     = (outst_q == CntMax);
    // Acks arriving with nothing outstanding are stale and get dropped.
    assign ack_ok   = bus.i_wb_ack && (outst_q != '0);
    assign accept   = (state_q == StBusy) && own_stb && !full && !bus.i_wb_stall;

    assign bus.o_m_wb_dat  = bus.i_wb_dat;
    assign bus.o_grant_idx = grant_q;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx = (ARB_MODE == 1) ? GntW'((32'(rr_ptr_q) + i) % NUM_MASTERS) : GntW'(i);
            if (!found && bus.i_m_wb_cyc[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        ptr_nxt = GntW'((32'(winner) + 32'd1) % NUM_MASTERS);
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        outst_d  = outst_q;
        timer_d  = '0;
        case (state_q)
            StIdle: begin
                if (any_cyc) begin
                    state_d  = StBusy;
                    grant_d  = winner;
                    rr_ptr_d = ptr_nxt;
                    outst_d  = '0;
                end
            end
            StBusy: begin
                if (accept && !ack_ok) begin
                    outst_d = outst_q + 1'b1;
                end else if (!accept && ack_ok) begin
                    outst_d = outst_q - 1'b1;
                end
                if ((TIMEOUT_CYCLES != 0) && (outst_q != '0) && !bus.i_wb_ack
                    && (timer_q == TmrLast)) begin
                    state_d = StAbort;
                    outst_d = '0;
                end else begin
                    if ((TIMEOUT_CYCLES != 0) && (outst_q != '0) && !bus.i_wb_ack) begin
                        timer_d = timer_q + 1'b1;
                    end
                    if (!own_cyc) begin
                        outst_d = '0;
                        timer_d = '0;
                        state_d = own_lock ? StHold : StIdle;
                    end
                end
            end
            StHold: begin
                if (own_cyc) begin
                    state_d = StBusy;
                end else if (!own_lock) begin
                    state_d = StIdle;
                end
            end
            StAbort: begin
                state_d = StIdle;
                outst_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.o_wb_adr     = '0;
        bus.o_wb_dat     = '0;
        bus.o_wb_we      = 1'b0;
        bus.o_wb_sel     = '0;
        bus.o_wb_stb     = 1'b0;
        bus.o_wb_cyc     = 1'b0;
        bus.o_m_wb_ack   = '0;
        bus.o_m_wb_rty   = '0;
        bus.o_m_wb_stall = '0;
        bus.o_busy       = 1'b0;
        case (state_q)
            // Everyone requesting is held off while the winner's grant is registered.
            StIdle: bus.o_m_wb_stall = {NUM_MASTERS{any_cyc}};
            StBusy: begin
                bus.o_wb_adr                  = bus.i_m_wb_adr[grant_q*ADDR_W +: ADDR_W];
                bus.o_wb_dat                  = bus.i_m_wb_dat[grant_q*DATA_W +: DATA_W];
                bus.o_wb_sel                  = bus.i_m_wb_sel[grant_q*SelW +: SelW];
                bus.o_wb_we                   = bus.i_m_wb_we[grant_q];
                bus.o_wb_cyc                  = own_cyc;
                bus.o_wb_stb                  = own_stb && !full;
                bus.o_m_wb_stall              = '1;
                bus.o_m_wb_stall[grant_q]     = bus.i_wb_stall || full;
                bus.o_m_wb_ack[grant_q]       = ack_ok;
                bus.o_busy                    = 1'b1;
            end
            StHold: begin
                bus.o_m_wb_stall = '1;
                bus.o_busy       = 1'b1;
            end
            StAbort: begin
                bus.o_m_wb_stall          = '1;
                bus.o_m_wb_rty[grant_q]   = 1'b1;
                bus.o_busy                = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            outst_q  <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            outst_q  <= outst_d;
            timer_q  <= timer_d;
        end
    end
endmodule

// File: tb/tb_wb_arbiter_n.sv
// Random-stimulus bench: a fixed-priority and a round-robin arbiter share one stimulus
// stream and are each compared every cycle against a transaction-level reference model.
module tb_wb_arbiter_n;
    localparam int N = 3, AW = 32, DW = 32, SW = 4, MAXO = 8, TMO = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*SW-1:0] m_sel;
    logic [N-1:0]    m_we, m_stb, m_cyc, m_lock;
    logic [DW-1:0]   s_dat;
    logic            s_ack, s_stall;

    wb_arbiter_n_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) if_fp ();
    wb_arbiter_n_if #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) if_rr ();

    assign if_fp.i_m_wb_adr = m_adr;   assign if_rr.i_m_wb_adr = m_adr;
    assign if_fp.i_m_wb_dat = m_dat;   assign if_rr.i_m_wb_dat = m_dat;
    assign if_fp.i_m_wb_sel = m_sel;   assign if_rr.i_m_wb_sel = m_sel;
    assign if_fp.i_m_wb_we  = m_we;    assign if_rr.i_m_wb_we  = m_we;
    assign if_fp.i_m_wb_stb = m_stb;   assign if_rr.i_m_wb_stb = m_stb;
    assign if_fp.i_m_wb_cyc = m_cyc;   assign if_rr.i_m_wb_cyc = m_cyc;
    assign if_fp.i_m_wb_lock = m_lock; assign if_rr.i_m_wb_lock = m_lock;
    assign if_fp.i_wb_dat   = s_dat;   assign if_rr.i_wb_dat   = s_dat;
    assign if_fp.i_wb_ack   = s_ack;   assign if_rr.i_wb_ack   = s_ack;
    assign if_fp.i_wb_stall = s_stall; assign if_rr.i_wb_stall = s_stall;

    wb_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0),
                   .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO))
        dut_fp (.i_clk(clk), .i_reset(rst_n), .bus(if_fp.slave));
    wb_arbiter_n #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1),
                   .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO))
        dut_rr (.i_clk(clk), .i_reset(rst_n), .bus(if_rr.slave));

    logic [N-1:0]  ob_ack[2], ob_stall[2], ob_rty[2];
    logic          ob_cyc[2], ob_stb[2], ob_we[2], ob_busy[2];
    logic [AW-1:0] ob_adr[2];
    logic [DW-1:0] ob_dat[2], ob_mdat[2];
    logic [SW-1:0] ob_sel[2];
    logic [1:0]    ob_gnt[2];

    assign ob_ack[0] = if_fp.o_m_wb_ack;     assign ob_ack[1] = if_rr.o_m_wb_ack;
    assign ob_stall[0] = if_fp.o_m_wb_stall; assign ob_stall[1] = if_rr.o_m_wb_stall;
    assign ob_rty[0] = if_fp.o_m_wb_rty;     assign ob_rty[1] = if_rr.o_m_wb_rty;
    assign ob_cyc[0] = if_fp.o_wb_cyc;       assign ob_cyc[1] = if_rr.o_wb_cyc;
    assign ob_stb[0] = if_fp.o_wb_stb;       assign ob_stb[1] = if_rr.o_wb_stb;
    assign ob_we[0] = if_fp.o_wb_we;         assign ob_we[1] = if_rr.o_wb_we;
    assign ob_busy[0] = if_fp.o_busy;        assign ob_busy[1] = if_rr.o_busy;
    assign ob_adr[0] = if_fp.o_wb_adr;       assign ob_adr[1] = if_rr.o_wb_adr;
    assign ob_dat[0] = if_fp.o_wb_dat;       assign ob_dat[1] = if_rr.o_wb_dat;
    assign ob_mdat[0] = if_fp.o_m_wb_dat;    assign ob_mdat[1] = if_rr.o_m_wb_dat;
    assign ob_sel[0] = if_fp.o_wb_sel;       assign ob_sel[1] = if_rr.o_wb_sel;
    assign ob_gnt[0] = if_fp.o_grant_idx;    assign ob_gnt[1] = if_rr.o_grant_idx;

    // Reference model, one copy per arbitration mode (0 fixed, 1 round-robin).
    int md_owner[2], md_ptr[2], md_cnt[2], md_stuck[2];
    bit md_owned[2], md_parked[2], md_abort[2];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int m, input int ptr, input logic [N-1:0] c);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m == 0) ? k : (ptr + k) % N;
            if (c[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            md_owner[m] = 0; md_ptr[m] = 0; md_cnt[m] = 0; md_stuck[m] = 0;
            md_owned[m] = 0; md_parked[m] = 0; md_abort[m] = 0;
        end
    endtask

    task automatic model_check(input int m);
        string nm;
        logic [N-1:0]  e_ack, e_stall, e_rty;
        logic          e_cyc, e_stb, e_we, e_busy;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        int o;
        nm = (m == 0) ? "fp" : "rr";
        o = md_owner[m];
        e_ack = '0; e_stall = '0; e_rty = '0; e_cyc = 0; e_stb = 0; e_we = 0; e_busy = 0;
        e_adr = '0; e_dat = '0; e_sel = '0;
        if (md_abort[m]) begin
            e_stall = '1; e_rty[o] = 1'b1; e_busy = 1;
        end else if (md_owned[m] && md_parked[m]) begin
            e_stall = '1; e_busy = 1;
        end else if (md_owned[m]) begin
            e_cyc = m_cyc[o];
            e_stb = m_stb[o] && (md_cnt[m] < MAXO);
            e_we = m_we[o];
            e_adr = m_adr[o*AW +: AW];
            e_dat = m_dat[o*DW +: DW];
            e_sel = m_sel[o*SW +: SW];
            e_stall = '1;
            e_stall[o] = s_stall || (md_cnt[m] == MAXO);
            e_ack[o] = s_ack && (md_cnt[m] > 0);
            e_busy = 1;
        end else begin
            e_stall = (|m_cyc) ? '1 : '0;
        end
        check_eq({nm, " ack"}, 64'(ob_ack[m]), 64'(e_ack));
        check_eq({nm, " stall"}, 64'(ob_stall[m]), 64'(e_stall));
        check_eq({nm, " rty"}, 64'(ob_rty[m]), 64'(e_rty));
        check_eq({nm, " wb_cyc"}, 64'(ob_cyc[m]), 64'(e_cyc));
        check_eq({nm, " wb_stb"}, 64'(ob_stb[m]), 64'(e_stb));
        check_eq({nm, " wb_we"}, 64'(ob_we[m]), 64'(e_we));
        check_eq({nm, " wb_adr"}, 64'(ob_adr[m]), 64'(e_adr));
        check_eq({nm, " wb_dat"}, 64'(ob_dat[m]), 64'(e_dat));
        check_eq({nm, " wb_sel"}, 64'(ob_sel[m]), 64'(e_sel));
        check_eq({nm, " m_dat"}, 64'(ob_mdat[m]), 64'(s_dat));
        check_eq({nm, " busy"}, 64'(ob_busy[m]), 64'(e_busy));
        if (e_busy) check_eq({nm, " grant"}, 64'(ob_gnt[m]), 64'(o));
    endtask

    task automatic model_advance(input int m);
        int o;
        bit took, got, waiting;
        o = md_owner[m];
        if (md_abort[m]) begin
            md_abort[m] = 0; md_owned[m] = 0; md_cnt[m] = 0;
        end else if (md_owned[m] && md_parked[m]) begin
            if (m_cyc[o]) begin
                md_parked[m] = 0; md_cnt[m] = 0; md_stuck[m] = 0;
            end else if (!m_lock[o]) begin
                md_owned[m] = 0; md_parked[m] = 0;
            end
        end else if (md_owned[m]) begin
            took = m_stb[o] && (md_cnt[m] < MAXO) && !s_stall;
            got = s_ack && (md_cnt[m] > 0);
            waiting = (md_cnt[m] > 0) && !s_ack;
            if (TMO != 0 && waiting && md_stuck[m] == TMO - 1) begin
                md_abort[m] = 1; md_cnt[m] = 0; md_stuck[m] = 0;
            end else if (!m_cyc[o]) begin
                md_cnt[m] = 0; md_stuck[m] = 0;
                if (m_lock[o]) md_parked[m] = 1;
                else md_owned[m] = 0;
            end else begin
                md_cnt[m] = md_cnt[m] + int'(took) - int'(got);
                md_stuck[m] = waiting ? md_stuck[m] + 1 : 0;
            end
        end else if (|m_cyc) begin
            md_owner[m] = pick(m, md_ptr[m], m_cyc);
            md_ptr[m] = (md_owner[m] + 1) % N;
            md_owned[m] = 1; md_parked[m] = 0; md_cnt[m] = 0; md_stuck[m] = 0;
        end
    endtask

    task automatic check_both();
        model_check(0);
        model_check(1);
    endtask

    task automatic advance_both();
        model_advance(0);
        model_advance(1);
    endtask

    task automatic randomize_data();
        m_adr = {$urandom, $urandom, $urandom};
        m_dat = {$urandom, $urandom, $urandom};
        m_sel = 12'($urandom);
        m_we = 3'($urandom);
        s_dat = $urandom;
    endtask

    // Called just after a rising edge; ends just after a rising edge.
    task automatic prio_scenario();
        for (int c = 0; c < 10; c++) begin
            m_cyc = (c < 5) ? 3'b101 : ((c < 9) ? 3'b100 : 3'b000);
            m_stb = m_cyc;
            m_lock = '0;
            s_ack = 1'b0;
            s_stall = 1'b0;
            randomize_data();
            #3;
            check_both();
            if (c == 1) begin
                check_eq("prio grant c1", 64'(ob_gnt[0]), 64'd0);
                check_eq("prio m2 stall c1", 64'(ob_stall[0][2]), 64'd1);
            end
            if (c == 7) check_eq("prio grant c7", 64'(ob_gnt[0]), 64'd2);
            advance_both();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_random(input int i);
        int phase, drop_pct, lock_pct, ack_pct;
        phase = (i / 200) % 4;
        drop_pct = (phase == 1 || phase == 2) ? 3 : 12;
        lock_pct = (phase == 3) ? 15 : 3;
        ack_pct = (phase == 2) ? 0 : ((phase == 1) ? 10 : 45);
        for (int k = 0; k < N; k++) begin
            if (m_cyc[k]) begin
                if ($urandom_range(99) < drop_pct) m_cyc[k] = 1'b0;
            end else if ($urandom_range(99) < 30) begin
                m_cyc[k] = 1'b1;
            end
            m_stb[k] = m_cyc[k] && ($urandom_range(99) < 70);
            if ($urandom_range(99) < lock_pct) m_lock[k] = ~m_lock[k];
        end
        randomize_data();
        s_stall = $urandom_range(99) < 25;
        s_ack = $urandom_range(99) < ack_pct;
    endtask

    initial begin
        rst_n = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_stb = '0; m_cyc = '0; m_lock = '0;
        s_dat = '0; s_ack = 1'b0; s_stall = 1'b0;
        model_reset();
        #4;
        check_both();
        check_eq("reset busy", 64'(ob_busy[0]), 64'd0);
        check_eq("reset stall", 64'(ob_stall[0]), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        check_both();
        advance_both();
        @(posedge clk);
        #1;
        prio_scenario();

        for (int i = 0; i < 2400; i++) begin
            drive_random(i);
            if (i == 1300) begin
                // Asynchronous reset in the middle of traffic.
                #1;
                rst_n = 1'b0;
                model_reset();
                #2;
                check_both();
                check_eq("async rst busy", 64'(ob_busy[0]), 64'd0);
                check_eq("async rst wb_cyc", 64'(ob_cyc[1]), 64'd0);
                @(posedge clk);
                #1;
                m_cyc = '0; m_stb = '0; m_lock = '0;
                #3;
                check_both();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                #3;
                check_both();
                advance_both();
                @(posedge clk);
                #1;
                prio_scenario();
            end else begin
                #3;
                check_both();
                advance_both();
                @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
